// File: rtl/psram_user_if_model_if.sv
// PSRAM user-port bundle: command/write side driven by the client (master),
// read data and status driven by the memory model (slave).
//   addr[20:0]      burst address, 64-bit-word units
//   cmd             1 = write, 0 = read
//   cmd_en          single-cycle command strobe
//   wr_data[63:0]   write beat data
//   data_mask[7:0]  bit i = 1 keeps byte i unchanged
//   rd_data[63:0]   read beat data, zero when not valid
//   rd_data_valid   qualifies rd_data
//   init_calib      model ready
//   cmd_err         sticky: a command was dropped
interface psram_user_if_model_if;
    logic [20:0] addr;
    logic        cmd;
    logic        cmd_en;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        init_calib;
    logic        cmd_err;

    modport master (
        output addr, cmd, cmd_en, wr_data, data_mask,
        input  rd_data, rd_data_valid, init_calib, cmd_err
    );

    modport slave (
        input  addr, cmd, cmd_en, wr_data, data_mask,
        output rd_data, rd_data_valid, init_calib, cmd_err
    );
endinterface

// File: rtl/psram_user_if_model.sv
// Behavioural stand-in for the PSRAM IP user port, backed by a 64-bit array.
// Lets frame-buffer clients be simulated and bring-up synthesised without the
// vendor IP or external devices.
//   clk    user clock, rising edge
//   reset  asynchronous, active-high
//   bus    psram_user_if_model_if.slave (command, write data, read data, status)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_INIT  | counting INIT_CYCLES after reset; commands dropped
// S_IDLE  | ready; cmd_en starts a write or read burst
// S_WRITE | sampling write beats 1..BURST_BEATS-1
// S_READ  | latency countdown, then BURST_BEATS valid read beats
module psram_user_if_model #(
    parameter int BURST_BEATS = 8,
    parameter int MEM_AW      = 10,
    parameter int INIT_CYCLES = 256,
    parameter int RD_LATENCY  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    psram_user_if_model_if.slave  bus
);

    localparam int BW  = $clog2(BURST_BEATS);
    localparam int BCW = BW + 1;
    localparam int LW  = $clog2(RD_LATENCY);
    localparam int IW  = $clog2(INIT_CYCLES + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_READ} state_t;

    state_t              state;
    logic [IW-1:0]       init_cnt;
    logic [BCW-1:0]      beat_cnt;
    logic [LW-1:0]       lat_cnt;
    logic [MEM_AW-1:0]   base_q;
    logic [63:0]         rd_data_q;
    logic                rd_valid_q;
    logic                init_calib_q;
    logic                cmd_err_q;

    logic [63:0]         mem [2**MEM_AW];

    logic [MEM_AW-1:0]   cmd_base;
    logic [MEM_AW-1:0]   beat_addr;
    logic [MEM_AW-1:0]   wr_addr;
    logic                wr_en;

    // Upper address bits alias; low bits are forced to the burst boundary.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[20:MEM_AW], bus.addr[BW-1:0]};

    assign cmd_base  = {bus.addr[MEM_AW-1:BW], {BW{1'b0}}};
    assign beat_addr = base_q | MEM_AW'(beat_cnt[BW-1:0]);

    // Beat 0 is written on the command edge itself, so the write address
    // comes straight from the bus while still in S_IDLE.
    assign wr_en   = ((state == S_IDLE) && bus.cmd_en && bus.cmd) || (state == S_WRITE);
    assign wr_addr = (state == S_IDLE) ? cmd_base : beat_addr;

    // Array is never reset; wr_data/data_mask only matter when wr_en is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (!bus.data_mask[b]) begin
                    mem[wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_INIT;
            init_cnt     <= IW'(INIT_CYCLES - 1);
            beat_cnt     <= '0;
            lat_cnt      <= '0;
            base_q       <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            init_calib_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (bus.cmd_en) begin
                        cmd_err_q <= 1'b1;
                    end
                    if (init_cnt == '0) begin
                        init_calib_q <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_en) begin
                        base_q <= cmd_base;
                        if (bus.cmd) begin
                            beat_cnt <= BCW'(1);
                            state    <= S_WRITE;
                        end else begin
                            beat_cnt <= '0;
                            lat_cnt  <= LW'(RD_LATENCY - 1);
                            state    <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.cmd_en) begin
                        cmd_err_q <= 1'b1;
                    end
                    if (beat_cnt == BCW'(BURST_BEATS - 1)) begin
                        beat_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (bus.cmd_en) begin
                        cmd_err_q <= 1'b1;
                    end
                    // Countdown reaches zero on the edge RD_LATENCY after the
                    // command edge; beats follow on consecutive edges, and the
                    // edge after the last beat drops valid and returns to idle.
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else if (beat_cnt == BCW'(BURST_BEATS)) begin
                        rd_valid_q <= 1'b0;
                        rd_data_q  <= '0;
                        beat_cnt   <= '0;
                        state      <= S_IDLE;
                    end else begin
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= mem[beat_addr];
                        beat_cnt   <= beat_cnt + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.init_calib    = init_calib_q;
    assign bus.cmd_err       = cmd_err_q;

endmodule

// File: tb/tb_psram_user_if_model.sv
module tb_psram_user_if_model;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] wbuf [8];
    logic [7:0]  mbuf [8];
    logic [63:0] ebuf [8];
    logic [63:0] rbuf [8];

    psram_user_if_model_if bus ();

    psram_user_if_model dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int k);
        logic [63:0] r;
        if (k == 0) return 64'hfedcba9876543210;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = 8'(8*k + i);
        return r;
    endfunction

    // Drives one burst from wbuf/mbuf; optionally strobes a read at beat inj.
    task automatic write_burst(input logic [20:0] a, input int inj);
        bus.addr = a; bus.cmd = 1'b1; bus.cmd_en = 1'b1;
        bus.wr_data = wbuf[0]; bus.data_mask = mbuf[0];
        tick();
        bus.cmd_en = 1'b0;
        for (int k = 1; k < 8; k++) begin
            bus.wr_data = wbuf[k]; bus.data_mask = mbuf[k];
            if (k == inj) begin bus.cmd_en = 1'b1; bus.cmd = 1'b0; bus.addr = 21'd0; end
            else bus.cmd_en = 1'b0;
            tick();
        end
        bus.cmd_en = 1'b0;
        bus.wr_data = 'x; bus.data_mask = 'x;
    endtask

    task automatic read_burst(input logic [20:0] a, output int lat, output bit pre_bad, output bit post_bad);
        bus.addr = a; bus.cmd = 1'b0; bus.cmd_en = 1'b1;
        tick();
        bus.cmd_en = 1'b0;
        lat = 0; pre_bad = 1'b0;
        while (!bus.rd_data_valid && lat < 40) begin
            if (bus.rd_data !== 64'd0) pre_bad = 1'b1;
            tick();
            lat++;
        end
        for (int k = 0; k < 8; k++) begin
            rbuf[k] = bus.rd_data_valid ? bus.rd_data : 'x;
            tick();
        end
        post_bad = (bus.rd_data_valid !== 1'b0) || (bus.rd_data !== 64'd0);
    endtask

    task automatic expect_read(input string tag, input logic [20:0] a);
        int lat; bit pre_bad; bit post_bad;
        read_burst(a, lat, pre_bad, post_bad);
        check({tag, "_latency"}, 64'(lat), 64'd12);
        check({tag, "_zero_before"}, 64'(pre_bad), 64'd0);
        for (int k = 0; k < 8; k++) check($sformatf("%s_beat%0d", tag, k), rbuf[k], ebuf[k]);
        check({tag, "_zero_after"}, 64'(post_bad), 64'd0);
    endtask

    // Counts edges after reset release until init_calib; optionally strobes a
    // write command on edge 3 while still initialising.
    task automatic init_count(input bit inject, output int first, output bit vseen);
        first = 0; vseen = 1'b0;
        for (int n = 1; n <= 400 && first == 0; n++) begin
            if (inject && n == 3) begin
                bus.cmd_en = 1'b1; bus.cmd = 1'b1; bus.addr = 21'd8;
                bus.wr_data = 64'd0; bus.data_mask = 8'h00;
            end
            if (inject && n == 4) bus.cmd_en = 1'b0;
            tick();
            if (bus.rd_data_valid) vseen = 1'b1;
            if (bus.init_calib) first = n;
        end
    endtask

    initial begin
        int  first;
        bit  vseen;
        int  n;

        reset = 1'b1;
        bus.cmd_en = 1'b0; bus.cmd = 1'b0; bus.addr = '0;
        bus.wr_data = '0; bus.data_mask = '0;

        #500;
        check("rst_init_calib", 64'(bus.init_calib), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_data_valid), 64'd0);
        check("rst_rd_data", bus.rd_data, 64'd0);
        check("rst_cmd_err", 64'(bus.cmd_err), 64'd0);
        #500;
        reset = 1'b0;

        init_count(1'b0, first, vseen);
        check("init_cycles", 64'(first), 64'd256);
        check("init_no_valid", 64'(vseen), 64'd0);

        // Full write then read-after-write at address 0.
        for (int k = 0; k < 8; k++) begin wbuf[k] = pat(k); mbuf[k] = 8'h00; ebuf[k] = pat(k); end
        write_burst(21'd0, -1);
        expect_read("rd0", 21'd0);

        // Byte-masked rewrite: only bytes 0 and 4 of beat 0 change.
        for (int k = 0; k < 8; k++) begin wbuf[k] = '1; mbuf[k] = 8'hFF; end
        mbuf[0] = 8'hEE;
        ebuf[0] = 64'hfedcbaff765432ff;
        write_burst(21'd0, -1);
        expect_read("mask", 21'd0);

        // Unaligned address lands on the burst boundary.
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 64'h1111111111111111; mbuf[k] = 8'h00; ebuf[k] = wbuf[k];
        end
        write_burst(21'd5, -1);
        expect_read("align", 21'd0);

        // Address bits above MEM_AW alias back onto word 0.
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 64'ha0a0000000000000 | 64'(k); mbuf[k] = 8'h00; ebuf[k] = wbuf[k];
        end
        write_burst(21'h400, -1);
        expect_read("alias", 21'd0);
        check("err_clean", 64'(bus.cmd_err), 64'd0);

        // Read strobe during a write burst is dropped.
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 64'hc0de000000000000 | 64'(k << 8) | 64'(k); mbuf[k] = 8'h00; ebuf[k] = wbuf[k];
        end
        write_burst(21'd8, 3);
        vseen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (bus.rd_data_valid) vseen = 1'b1;
            tick();
        end
        check("drop_no_valid", 64'(vseen), 64'd0);
        check("drop_cmd_err", 64'(bus.cmd_err), 64'd1);
        expect_read("drop", 21'd8);

        // Reset during beat 3 of a read.
        bus.addr = 21'd8; bus.cmd = 1'b0; bus.cmd_en = 1'b1;
        tick();
        bus.cmd_en = 1'b0;
        n = 0;
        while (!bus.rd_data_valid && n < 40) begin tick(); n++; end
        tick(); tick(); tick();
        check("midrd_valid", 64'(bus.rd_data_valid), 64'd1);
        check("midrd_beat3", bus.rd_data, ebuf[3]);
        reset = 1'b1;
        #1;
        check("midrst_valid", 64'(bus.rd_data_valid), 64'd0);
        check("midrst_init_calib", 64'(bus.init_calib), 64'd0);
        check("midrst_rd_data", bus.rd_data, 64'd0);
        check("midrst_cmd_err", 64'(bus.cmd_err), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Write strobe during INIT is dropped and flagged.
        init_count(1'b1, first, vseen);
        check("reinit_cycles", 64'(first), 64'd256);
        check("reinit_no_valid", 64'(vseen), 64'd0);
        check("init_cmd_err", 64'(bus.cmd_err), 64'd1);
        expect_read("after_rst", 21'd8);
        check("err_sticky", 64'(bus.cmd_err), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
